// File: rtl/adder_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin adder arbiter.
//   tag_t    : requester index carried through the tag FIFO (default N=4)
//   pick_t   : result of a round-robin scan {found, idx}
//   rr_pick  : scan a valid vector upward from a pointer, modulo n
//   ORPHAN_* : values of the sticky orphan-result flag
package adder_arb_pkg;

  localparam int ARB_N = 4;
  typedef logic [$clog2(ARB_N)-1:0] tag_t;

  // rr_pick works on vectors up to MAX_N wide; callers zero-extend.
  localparam int MAX_N = 16;
  localparam int VAL_W = 4;          // index width into a MAX_N vector
  localparam int IDX_W = VAL_W + 1;  // wide enough to also hold MAX_N itself

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  localparam logic ORPHAN_CLEAR = 1'b0;
  localparam logic ORPHAN_SET   = 1'b1;

  // Returns the first set bit at or after ptr (wrapping at n).
  function automatic pick_t rr_pick(input logic [MAX_N-1:0] valid,
                                    input logic [IDX_W-1:0] ptr,
                                    input logic [IDX_W-1:0] n);
    pick_t            res;
    logic [IDX_W:0]   cand;
    res = '0;
    // Walk from the farthest offset to the nearest so the nearest hit wins.
    for (int i = MAX_N - 1; i >= 0; i--) begin
      cand = {1'b0, ptr} + (IDX_W + 1)'(i);
      if (cand >= {1'b0, n}) begin
        cand = cand - {1'b0, n};
      end else begin
        cand = cand;
      end
      if ((IDX_W'(i) < n) && valid[cand[VAL_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[IDX_W-1:0];
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/adder_rr_arbiter_if.sv
// Bus bundle between N requesters, the arbiter and the shared adder.
//   req_*     : per-requester operand handshake (operands packed i*W +: W)
//   rsp_*     : per-requester sum handshake, sum broadcast
//   add_in_*  : arbiter -> adder operand handshake
//   add_out_* : adder -> arbiter result handshake
// Modports: master = arbiter view, slave = requesters plus adder view.
interface adder_rr_arbiter_if #(
  parameter int N = 4,
  parameter int W = 32
);
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic [W-1:0]   rsp_sum;
  logic           add_in_valid;
  logic           add_in_ready;
  logic [W-1:0]   add_in_a;
  logic [W-1:0]   add_in_b;
  logic           add_out_valid;
  logic           add_out_ready;
  logic [W-1:0]   add_out_sum;

  modport master (
    input  req_valid, req_a, req_b, rsp_ready, add_in_ready, add_out_valid, add_out_sum,
    output req_ready, rsp_valid, rsp_sum, add_in_valid, add_in_a, add_in_b, add_out_ready
  );

  modport slave (
    output req_valid, req_a, req_b, rsp_ready, add_in_ready, add_out_valid, add_out_sum,
    input  req_ready, rsp_valid, rsp_sum, add_in_valid, add_in_a, add_in_b, add_out_ready
  );
endinterface

// File: rtl/adder_rr_arbiter_tag_fifo.sv
// In-order tag FIFO recording which requester owns each in-flight add.
// Ports: clk, rst_n (sync, active-low), push/pop requests, din/dout tag,
//        full/empty flags, count of stored tags. DEPTH must be a power of 2.
module arb_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_r;
  logic [PW-1:0]    rd_r;
  logic [CW-1:0]    cnt_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify requests against the current occupancy.
  always_comb begin
    do_push_s = push & ~full;
    do_pop_s  = pop & ~empty;
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is 2^k.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_r  <= {PW{1'b0}};
      rd_r  <= {PW{1'b0}};
      cnt_r <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_r <= wr_r + PW'(1);
      if (do_pop_s)  rd_r <= rd_r + PW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_r <= cnt_r + CW'(1);
        2'b01:   cnt_r <= cnt_r - CW'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Tag storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
    end else if (do_push_s) begin
      mem_r[wr_r] <= din;
    end
  end

  assign dout  = mem_r[rd_r];
  assign full  = (cnt_r == CW'(DEPTH));
  assign empty = (cnt_r == {CW{1'b0}});
  assign count = cnt_r;
endmodule

// File: rtl/adder_rr_arbiter.sv
// Shares one ready/valid adder among N requesters with round-robin grants.
// Each issued operand pair records its requester tag in an in-order FIFO;
// returning sums are steered to the requester at the FIFO head.
// Ports: clk, rst_n (sync, active-low), bus (master modport: requester and
//        adder handshakes), outstanding (tags in flight), err_orphan (sticky:
//        adder result seen with no tag outstanding). N must not exceed 16.
module adder_rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  adder_rr_arbiter_if.master         bus,
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic                       err_orphan
);
  localparam int TW = $clog2(N);

  logic [TW-1:0]       rr_ptr_r;
  logic                err_orphan_r;
  logic [MAX_N-1:0]    valid_ext_s;
  pick_t               pick_s;
  logic [IDX_W-TW-1:0] pick_unused_s;
  logic [TW-1:0]       grant_s;
  logic [TW-1:0]       head_s;
  logic                issue_ok_s;
  logic                push_s;
  logic                pop_s;
  logic                out_ready_s;
  logic                full_s;
  logic                empty_s;

  // Round-robin scan starting at rr_ptr.
  always_comb begin
    valid_ext_s        = {MAX_N{1'b0}};
    valid_ext_s[N-1:0] = bus.req_valid;
    pick_s             = rr_pick(valid_ext_s, IDX_W'(rr_ptr_r), IDX_W'(N));
    {pick_unused_s, grant_s} = pick_s.idx;
  end

  // Issue path: grant mux toward the adder; stalls whenever the tag FIFO is full.
  always_comb begin
    issue_ok_s       = pick_s.found & ~full_s;
    push_s           = issue_ok_s & bus.add_in_ready;
    bus.add_in_valid = issue_ok_s;
    bus.add_in_a     = {W{1'b0}};
    bus.add_in_b     = {W{1'b0}};
    bus.req_ready    = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (issue_ok_s && (grant_s == TW'(i))) begin
        bus.add_in_a     = bus.req_a[i*W +: W];
        bus.add_in_b     = bus.req_b[i*W +: W];
        bus.req_ready[i] = bus.add_in_ready;
      end else begin
        bus.req_ready[i] = 1'b0;
      end
    end
  end

  // Response path: steer the adder result to the owner of the head tag.
  always_comb begin
    out_ready_s           = ~empty_s & bus.rsp_ready[head_s];
    bus.add_out_ready     = out_ready_s;
    bus.rsp_sum           = bus.add_out_sum;
    bus.rsp_valid         = {N{1'b0}};
    bus.rsp_valid[head_s] = bus.add_out_valid & ~empty_s;
    pop_s                 = bus.add_out_valid & out_ready_s;
  end

  // Pointer advances past the granted port only when the issue actually fires.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_r <= {TW{1'b0}};
    end else if (push_s) begin
      rr_ptr_r <= (grant_s == TW'(N - 1)) ? {TW{1'b0}} : grant_s + TW'(1);
    end
  end

  // Sticky flag for a result arriving with nothing outstanding.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_orphan_r <= ORPHAN_CLEAR;
    end else if (bus.add_out_valid && empty_s) begin
      err_orphan_r <= ORPHAN_SET;
    end
  end

  assign err_orphan = err_orphan_r;

  arb_tag_fifo #(
    .WIDTH (TW),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .din   (grant_s),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (outstanding)
  );
endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed bench for adder_rr_arbiter with a behavioural in-order adder
// (1-cycle latency, 8 entries) standing in for the real adder.
module tb_adder_rr_arbiter;
  import adder_arb_pkg::*;

  localparam int N = 4;
  localparam int W = 32;
  localparam int DEPTH = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] outstanding;
  logic       err_orphan;

  adder_rr_arbiter_if #(.N(N), .W(W)) bus();

  adder_rr_arbiter #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .outstanding (outstanding),
    .err_orphan  (err_orphan)
  );

  always #5 clk = ~clk;

  // Behavioural adder
  logic [W-1:0] m_mem [8];
  logic [2:0]   m_wr  = 3'd0;
  logic [2:0]   m_rd  = 3'd0;
  int           m_cnt = 0;
  logic         force_ov = 1'b0;

  assign bus.add_in_ready  = (m_cnt < 8);
  assign bus.add_out_valid = force_ov | (m_cnt != 0);
  assign bus.add_out_sum   = force_ov ? 32'hDEAD_BEEF : m_mem[m_rd];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_wr <= 3'd0; m_rd <= 3'd0; m_cnt <= 0;
    end else begin
      if (bus.add_in_valid && bus.add_in_ready) begin
        m_mem[m_wr] <= bus.add_in_a + bus.add_in_b;
        m_wr <= m_wr + 3'd1;
      end
      if (bus.add_out_valid && bus.add_out_ready && m_cnt != 0) m_rd <= m_rd + 3'd1;
      m_cnt <= m_cnt + ((bus.add_in_valid && bus.add_in_ready) ? 1 : 0)
                     - ((bus.add_out_valid && bus.add_out_ready && m_cnt != 0) ? 1 : 0);
    end
  end

  // Monitor: sample handshakes mid-cycle, log issues and responses
  int           iss_n = 0;
  int           rsp_n = 0;
  int           iss_port [128];
  int           rsp_port [128];
  logic [W-1:0] rsp_val  [128];
  int           fire_cnt [4] = '{0, 0, 0, 0};

  function automatic int oh_idx(input logic [3:0] v);
    case (v)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (|(bus.req_valid & bus.req_ready)) begin
        iss_port[iss_n] <= oh_idx(bus.req_valid & bus.req_ready);
        iss_n <= iss_n + 1;
        fire_cnt[oh_idx(bus.req_valid & bus.req_ready)] <= fire_cnt[oh_idx(bus.req_valid & bus.req_ready)] + 1;
      end
      if (|(bus.rsp_valid & bus.rsp_ready)) begin
        rsp_port[rsp_n] <= oh_idx(bus.rsp_valid & bus.rsp_ready);
        rsp_val[rsp_n]  <= bus.rsp_sum;
        rsp_n <= rsp_n + 1;
      end
    end
  end

  // Requester driver state
  int           pend_n [4] = '{0, 0, 0, 0};
  logic [W-1:0] pend_a [4];
  logic [W-1:0] pend_b [4];
  int           seen   [4] = '{0, 0, 0, 0};

  // Per-port operands used in the multi-port tests, with hand-computed sums
  logic [W-1:0] op_a  [4] = '{32'h0000_0010, 32'h0000_0200, 32'h0000_3000, 32'h0004_0000};
  logic [W-1:0] op_b  [4] = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004};
  logic [W-1:0] exp_s [4] = '{32'h0000_0011, 32'h0000_0202, 32'h0000_3003, 32'h0004_0004};

  int tests = 0;
  int fails = 0;

  task automatic drive();
    bus.req_valid = {pend_n[3] > 0, pend_n[2] > 0, pend_n[1] > 0, pend_n[0] > 0};
    bus.req_a     = {pend_a[3], pend_a[2], pend_a[1], pend_a[0]};
    bus.req_b     = {pend_b[3], pend_b[2], pend_b[1], pend_b[0]};
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (fire_cnt[i] != seen[i]) begin
        seen[i] = fire_cnt[i];
        if (pend_n[i] > 0) pend_n[i] = pend_n[i] - 1;
      end
    end
    drive();
    #1;
  endtask

  task automatic load(input int p, input logic [W-1:0] a, input logic [W-1:0] b, input int n);
    pend_a[p] = a; pend_b[p] = b; pend_n[p] = n;
    drive();
  endtask

  task automatic apply_reset();
    for (int i = 0; i < N; i++) pend_n[i] = 0;
    drive();
    force_ov = 1'b0;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) seen[i] = fire_cnt[i];
    #1;
  endtask

  task automatic run_rsp(input int target, input int budget, input string name);
    for (int c = 0; c < budget && rsp_n < target; c++) cycle();
    tests++;
    if (rsp_n < target) begin
      fails++;
      $display("FAIL %s_timeout: got %0d responses, expected %0d", name, rsp_n, target);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    tests++; if (outstanding !== 3'd0) begin fails++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
    tests++; if (err_orphan !== 1'b0) begin fails++; $display("FAIL reset_err_orphan: got %b expected 0", err_orphan); end
    tests++; if (bus.req_ready !== 4'b0000) begin fails++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready); end
    tests++; if (bus.rsp_valid !== 4'b0000) begin fails++; $display("FAIL reset_rsp_valid: got %b expected 0000", bus.rsp_valid); end
    tests++; if (bus.add_in_valid !== 1'b0) begin fails++; $display("FAIL reset_add_in_valid: got %b expected 0", bus.add_in_valid); end
    tests++; if (bus.add_out_ready !== 1'b0) begin fails++; $display("FAIL reset_add_out_ready: got %b expected 0", bus.add_out_ready); end
  endtask

  task automatic test_single();
    int rb;
    apply_reset();
    rb = rsp_n;
    load(0, 32'h0000_0003, 32'h0000_0004, 1);
    #1;
    tests++; if (bus.add_in_a !== 32'h0000_0003) begin fails++; $display("FAIL single_add_in_a: got %h expected 00000003", bus.add_in_a); end
    run_rsp(rb + 1, 20, "single");
    tests++; if (rsp_port[rb] !== 0) begin fails++; $display("FAIL single_port: got %0d expected 0", rsp_port[rb]); end
    tests++; if (rsp_val[rb] !== 32'h0000_0007) begin fails++; $display("FAIL single_sum: got %h expected 00000007", rsp_val[rb]); end
    tests++; if (outstanding !== 3'd0) begin fails++; $display("FAIL single_outstanding: got %0d expected 0", outstanding); end
  endtask

  task automatic test_round_robin();
    int ib, rb;
    apply_reset();
    ib = iss_n; rb = rsp_n;
    for (int i = 0; i < N; i++) load(i, op_a[i], op_b[i], 2);
    run_rsp(rb + 8, 40, "rr");
    for (int j = 0; j < 8; j++) begin
      tests++; if (iss_port[ib + j] !== j % 4) begin fails++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", j, iss_port[ib + j], j % 4); end
      tests++; if (rsp_port[rb + j] !== j % 4) begin fails++; $display("FAIL rr_rsp_port[%0d]: got %0d expected %0d", j, rsp_port[rb + j], j % 4); end
      tests++; if (rsp_val[rb + j] !== exp_s[j % 4]) begin fails++; $display("FAIL rr_rsp_sum[%0d]: got %h expected %h", j, rsp_val[rb + j], exp_s[j % 4]); end
    end
  endtask

  task automatic test_full();
    int ib, rb;
    apply_reset();
    ib = iss_n; rb = rsp_n;
    bus.rsp_ready = 4'b0000;
    for (int i = 0; i < N; i++) load(i, op_a[i], op_b[i], 3);
    for (int c = 0; c < 8; c++) cycle();
    tests++; if (iss_n - ib !== DEPTH) begin fails++; $display("FAIL full_issued: got %0d expected %0d", iss_n - ib, DEPTH); end
    tests++; if (outstanding !== 3'd4) begin fails++; $display("FAIL full_outstanding: got %0d expected 4", outstanding); end
    tests++; if (bus.req_ready !== 4'b0000) begin fails++; $display("FAIL full_req_ready: got %b expected 0000", bus.req_ready); end
    tests++; if (bus.add_in_valid !== 1'b0) begin fails++; $display("FAIL full_add_in_valid: got %b expected 0", bus.add_in_valid); end
    tests++; if (bus.rsp_valid !== 4'b0001) begin fails++; $display("FAIL full_rsp_valid: got %b expected 0001", bus.rsp_valid); end
    tests++; if (bus.add_out_ready !== 1'b0) begin fails++; $display("FAIL full_add_out_ready: got %b expected 0", bus.add_out_ready); end
    bus.rsp_ready = 4'b1111;
    run_rsp(rb + 12, 80, "full");
    for (int j = 0; j < 12; j++) begin
      tests++; if (rsp_port[rb + j] !== j % 4) begin fails++; $display("FAIL full_rsp_port[%0d]: got %0d expected %0d", j, rsp_port[rb + j], j % 4); end
    end
    for (int j = 0; j < 4; j++) begin
      tests++; if (rsp_val[rb + j] !== exp_s[j]) begin fails++; $display("FAIL full_rsp_sum[%0d]: got %h expected %h", j, rsp_val[rb + j], exp_s[j]); end
    end
    tests++; if (iss_n - ib !== 12) begin fails++; $display("FAIL full_resume_issued: got %0d expected 12", iss_n - ib); end
  endtask

  task automatic test_no_reorder();
    int ib, rb;
    apply_reset();
    ib = iss_n; rb = rsp_n;
    bus.rsp_ready = 4'b1011;
    load(2, 32'hFFFF_FFFF, 32'h0000_0001, 1);
    cycle();
    load(0, 32'h0000_0005, 32'h0000_0006, 1);
    for (int c = 0; c < 3; c++) cycle();
    tests++; if (iss_port[ib] !== 2 || iss_port[ib + 1] !== 0) begin fails++; $display("FAIL hol_issue_order: got %0d,%0d expected 2,0", iss_port[ib], iss_port[ib + 1]); end
    tests++; if (rsp_n !== rb) begin fails++; $display("FAIL hol_no_rsp: got %0d responses expected 0", rsp_n - rb); end
    tests++; if (bus.add_out_ready !== 1'b0) begin fails++; $display("FAIL hol_add_out_ready: got %b expected 0", bus.add_out_ready); end
    tests++; if (bus.rsp_valid !== 4'b0100) begin fails++; $display("FAIL hol_rsp_valid: got %b expected 0100", bus.rsp_valid); end
    tests++; if (outstanding !== 3'd2) begin fails++; $display("FAIL hol_outstanding: got %0d expected 2", outstanding); end
    bus.rsp_ready = 4'b1111;
    run_rsp(rb + 2, 20, "hol");
    tests++; if (rsp_port[rb] !== 2) begin fails++; $display("FAIL hol_first_port: got %0d expected 2", rsp_port[rb]); end
    tests++; if (rsp_val[rb] !== 32'h0000_0000) begin fails++; $display("FAIL hol_wrap_sum: got %h expected 00000000", rsp_val[rb]); end
    tests++; if (rsp_port[rb + 1] !== 0) begin fails++; $display("FAIL hol_second_port: got %0d expected 0", rsp_port[rb + 1]); end
    tests++; if (rsp_val[rb + 1] !== 32'h0000_000B) begin fails++; $display("FAIL hol_second_sum: got %h expected 0000000b", rsp_val[rb + 1]); end
  endtask

  task automatic test_reset_midflight();
    int rb;
    apply_reset();
    bus.rsp_ready = 4'b0000;
    for (int i = 0; i < 3; i++) load(i, op_a[i], op_b[i], 1);
    for (int c = 0; c < 6; c++) cycle();
    tests++; if (outstanding !== 3'd3) begin fails++; $display("FAIL midrst_inflight: got %0d expected 3", outstanding); end
    apply_reset();
    tests++; if (outstanding !== 3'd0) begin fails++; $display("FAIL midrst_outstanding: got %0d expected 0", outstanding); end
    tests++; if (bus.rsp_valid !== 4'b0000) begin fails++; $display("FAIL midrst_rsp_valid: got %b expected 0000", bus.rsp_valid); end
    rb = rsp_n;
    bus.rsp_ready = 4'b1111;
    for (int i = 0; i < N; i++) load(i, op_a[i], op_b[i], 1);
    #1;
    tests++; if (bus.req_ready !== 4'b0001) begin fails++; $display("FAIL midrst_next_grant: got %b expected 0001", bus.req_ready); end
    tests++; if (bus.add_in_a !== 32'h0000_0010) begin fails++; $display("FAIL midrst_add_in_a: got %h expected 00000010", bus.add_in_a); end
    run_rsp(rb + 4, 30, "midrst");
    tests++; if (rsp_port[rb] !== 0) begin fails++; $display("FAIL midrst_first_rsp: got %0d expected 0", rsp_port[rb]); end
  endtask

  task automatic test_orphan();
    apply_reset();
    force_ov = 1'b1;
    #1;
    tests++; if (bus.rsp_valid !== 4'b0000) begin fails++; $display("FAIL orphan_rsp_valid: got %b expected 0000", bus.rsp_valid); end
    tests++; if (bus.add_out_ready !== 1'b0) begin fails++; $display("FAIL orphan_add_out_ready: got %b expected 0", bus.add_out_ready); end
    tests++; if (err_orphan !== ORPHAN_CLEAR) begin fails++; $display("FAIL orphan_before_edge: got %b expected %b", err_orphan, ORPHAN_CLEAR); end
    cycle();
    force_ov = 1'b0;
    #1;
    tests++; if (err_orphan !== ORPHAN_SET) begin fails++; $display("FAIL orphan_set: got %b expected %b", err_orphan, ORPHAN_SET); end
    for (int c = 0; c < 3; c++) cycle();
    tests++; if (err_orphan !== ORPHAN_SET) begin fails++; $display("FAIL orphan_sticky: got %b expected %b", err_orphan, ORPHAN_SET); end
    apply_reset();
    tests++; if (err_orphan !== ORPHAN_CLEAR) begin fails++; $display("FAIL orphan_cleared: got %b expected %b", err_orphan, ORPHAN_CLEAR); end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin pend_a[i] = 32'h0; pend_b[i] = 32'h0; end
    bus.rsp_ready = 4'b1111;
    drive();
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_no_reorder();
    test_reset_midflight();
    test_orphan();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
